// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the sequencer FSM state encoding.
// Imported by the UART/ALU sequencer and any block that decodes opcodes.
package alu_pkg;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] XOR = 6'b100110;
   localparam logic [5:0] SRA = 6'b000011;
   localparam logic [5:0] SRL = 6'b000010;
   localparam logic [5:0] NOR = 6'b100111;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

endpackage

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B, opcode from UART; one-cycle ALU strobe, then transmits the result (opcode byte -> tx_start: 2 cycles).
// No rx backpressure: bytes arriving while executing/transmitting are dropped and flagged with a one-cycle overrun pulse.
module alu_uart_interface
   import alu_pkg::*;
#(
   parameter int NB_DATA_BUS = 8,
   parameter int NB_OPCODE   = 6
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_done,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic [NB_DATA_BUS-1:0] o_first_operator,
   output logic [NB_DATA_BUS-1:0] o_second_operator,
   output logic [NB_OPCODE-1:0]   o_opcode,
   output logic                   o_alu_valid,
   input  logic [NB_DATA_BUS-1:0] i_alu_result,
   output logic                   o_rx_overrun,
   output logic                   o_busy
);

   state_t state;

   // Outputs are set on entry to the state that owns them, so every strobe is a clean register.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state             <= WAIT_A;
         o_first_operator  <= '0;
         o_second_operator <= '0;
         o_opcode          <= '0;
         o_alu_valid       <= 1'b0;
         o_tx_start        <= 1'b0;
         o_tx_data         <= '0;
         o_rx_overrun      <= 1'b0;
         o_busy            <= 1'b0;
      end else begin
         o_alu_valid  <= 1'b0;
         o_tx_start   <= 1'b0;
         o_rx_overrun <= 1'b0;
         case (state)
            WAIT_A: begin
               if (i_rx_done) begin
                  o_first_operator <= i_rx_data;
                  o_busy           <= 1'b1;
                  state            <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (i_rx_done) begin
                  o_second_operator <= i_rx_data;
                  state             <= WAIT_OP;
               end
            end
            WAIT_OP: begin
               if (i_rx_done) begin
                  o_opcode    <= i_rx_data[NB_OPCODE-1:0];
                  o_alu_valid <= 1'b1;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               // ALU output is gated by o_alu_valid, which is high exactly this cycle.
               o_tx_data    <= i_alu_result;
               o_tx_start   <= 1'b1;
               o_rx_overrun <= i_rx_done;
               state        <= SEND;
            end
            SEND: begin
               o_rx_overrun <= i_rx_done;
               state        <= WAIT_TX;
            end
            WAIT_TX: begin
               o_rx_overrun <= i_rx_done;
               if (i_tx_done) begin
                  o_busy <= 1'b0;
                  state  <= WAIT_A;
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= WAIT_A;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequencer between the UART byte link and the combinational `alu`. It collects three received bytes in fixed order: first operand, second operand, opcode. It then drives them to the ALU for one cycle with `o_alu_valid` high and captures the result. Finally it sends the result byte back through the UART transmitter and waits for the transmitter to finish. It sits at the top level between `uart_rx`/`uart_tx` and `alu`.

## Interface
Parameters:
- `NB_DATA_BUS`, 8, operand/result width; only 8 is legal (one UART byte per operand).
- `NB_OPCODE`, 6, opcode width; the opcode is taken from the byte's low `NB_OPCODE` bits.

Ports:
- `i_clock` in 1 — single clock; all logic is on its rising edge.
- `i_reset` in 1 — synchronous, active-low reset.
- `i_rx_data` in 8 — received byte; valid when `i_rx_done`=1.
- `i_rx_done` in 1 — one-cycle pulse per received byte.
- `o_tx_data` out 8 — byte to transmit; held stable from `o_tx_start` until `i_tx_done`.
- `o_tx_start` out 1 — one-cycle pulse requesting transmission.
- `i_tx_done` in 1 — one-cycle pulse when the transmitter finishes a byte.
- `o_first_operator` out `NB_DATA_BUS` — registered operand A to the ALU.
- `o_second_operator` out `NB_DATA_BUS` — registered operand B to the ALU.
- `o_opcode` out `NB_OPCODE` — registered opcode to the ALU.
- `o_alu_valid` out 1 — ALU enable; high for exactly one cycle per operation.
- `i_alu_result` in `NB_DATA_BUS` — combinational ALU result.
- `o_rx_overrun` out 1 — one-cycle pulse when a received byte is dropped.
- `o_busy` out 1 — high in every state except `WAIT_A`.

## Operation
- **Reset** (`i_reset`=0 at a clock edge): state goes to `WAIT_A`. All outputs, operand/opcode registers and the result register go to 0. Reset has priority over every other event, in any state.
- **FSM states:**
  - `WAIT_A`: on `i_rx_done`, load `o_first_operator`, go to `WAIT_B`.
  - `WAIT_B`: on `i_rx_done`, load `o_second_operator`, go to `WAIT_OP`.
  - `WAIT_OP`: on `i_rx_done`, load `o_opcode` from `i_rx_data[NB_OPCODE-1:0]`, go to `EXEC`.
  - `EXEC`: `o_alu_valid`=1; capture `i_alu_result` into the result register; go to `SEND` unconditionally.
  - `SEND`: `o_tx_start`=1 with `o_tx_data`=result; go to `WAIT_TX` unconditionally.
  - `WAIT_TX`: hold `o_tx_data`; on `i_tx_done`, go to `WAIT_A`.
- **Dropped bytes:** an `i_rx_done` arriving in `EXEC`, `SEND` or `WAIT_TX` is discarded. `o_rx_overrun` pulses the following cycle. Operand registers are not modified.
- **Stray tx-done:** `i_tx_done` outside `WAIT_TX` is ignored.
- **Opcode handling:** opcodes are not checked. An undefined opcode is executed as-is; the ALU returns 0 and 0x00 is transmitted.
- **Held values:** operand and opcode registers keep their last values between operations. `o_alu_valid`=0 forces the ALU output to 0, so no stale result is ever captured.
- **No timeout:** a partially received triple waits indefinitely; only reset clears it.

## Timing
- Opcode-byte `i_rx_done` at cycle n gives:
  - `o_alu_valid`=1 at n+1 (operands and opcode already registered and stable);
  - `o_tx_start`=1 at n+2.
- Total latency from opcode byte to tx request: 2 cycles.
- `o_alu_valid` and `o_tx_start` are registered outputs (Moore decode), never high in the same cycle, each high exactly one cycle per operation.
- Back-to-back: an `i_rx_done` in the same cycle as `i_tx_done` in `WAIT_TX` is dropped (state is still `WAIT_TX`). The earliest accepted next byte is one cycle after `i_tx_done`.
- Throughput is bounded by the UART: one result per 3 received bytes plus 1 transmitted byte.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111;
  - the FSM state encoding (6 states, 3 bits).
- No sub-module: a single FSM plus registers.
- `alu`, `uart_rx`, `uart_tx` and this block are instantiated side by side in the top level; `alu` is not instantiated inside this block.

## Test plan
- **ADD:** rx bytes 0x05, 0x03, 0x20 → `o_alu_valid` pulse 1 cycle after the third `i_rx_done`; `o_tx_start` 2 cycles after, with `o_tx_data`=0x08; return to `WAIT_A` after `i_tx_done`.
- **SUB / SRA, signed:**
  - 0x03, 0x05, 0x22 → tx 0xFE.
  - 0x80, 0x01, 0x03 → tx 0xC0.
- **Undefined opcode:** 0x12, 0x34, 0x3F → tx 0x00; the FSM completes normally.
- **Overrun:** an extra rx byte 0xAA in `WAIT_TX` → `o_rx_overrun` pulses once, operand A unchanged, no extra tx. The next triple 0x01, 0x01, 0x25 (OR) → tx 0x01.
- **Reset mid-operation:** assert `i_reset`=0 in `WAIT_OP` and, separately, in `WAIT_TX` → next cycle all outputs are 0 and `o_busy`=0. A fresh triple 0x0F, 0xF0, 0x26 (XOR) → tx 0xFF.
- **Stray tx-done:** `i_tx_done` pulses in `WAIT_A`/`WAIT_B` → ignored. A coincident `i_rx_done`+`i_tx_done` in `WAIT_TX` → byte dropped with an overrun pulse.
